// File: rtl/tl_pkg.sv
// Shared TileLink constants for the probe fan-out slice: opcodes, cap params,
// FSM state type and the client-ID width helper.
package tl_pkg;

  localparam logic [2:0] B_PROBE          = 3'd6;
  localparam logic [2:0] C_PROBE_ACK      = 3'd4;
  localparam logic [2:0] C_PROBE_ACK_DATA = 3'd5;

  localparam logic [2:0] PARAM_TO_T = 3'd0;
  localparam logic [2:0] PARAM_TO_B = 3'd1;
  localparam logic [2:0] PARAM_TO_N = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } fan_state_e;

  // Client IDs need at least one bit even with a single client.
  function automatic int cid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_prio_enc.sv
// Lowest-set-bit encoder: returns the one-hot and binary index of the lowest
// asserted request bit, plus a valid flag when any bit is set.
module tl_prio_enc
  import tl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = cid_w(N)
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + N'(1));
  assign valid_o  = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/tl_probe_fanout.sv
// Serialises one sharer-mask probe request into per-client B probes, gathers
// the ProbeAck[Data] responses and reports a single completion.
module tl_probe_fanout
  import tl_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int SOURCE_W   = 4,
  parameter int M_SOURCE_W = SOURCE_W + $clog2(N_CLIENTS),
  localparam int CID_W     = cid_w(N_CLIENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_param_i,
  input  logic [3:0]            req_size_i,
  input  logic [SOURCE_W-1:0]   req_source_i,
  input  logic [ADDR_W-1:0]     req_address_i,
  input  logic [N_CLIENTS-1:0]  req_mask_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [2:0]            b_opcode_o,
  output logic [2:0]            b_param_o,
  output logic [3:0]            b_size_o,
  output logic [SOURCE_W-1:0]   b_source_o,
  output logic [ADDR_W-1:0]     b_address_o,
  output logic [7:0]            b_mask_o,
  output logic [DATA_W-1:0]     b_data_o,
  output logic                  b_corrupt_o,
  output logic [CID_W-1:0]      b_dest_o,
  input  logic                  pa_valid_i,
  output logic                  pa_ready_o,
  input  logic [2:0]            pa_opcode_i,
  input  logic [2:0]            pa_param_i,
  input  logic [3:0]            pa_size_i,
  input  logic [M_SOURCE_W-1:0] pa_source_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic                  done_dirty_o,
  output logic [N_CLIENTS-1:0]  done_acked_o,
  output logic                  err_o
);

  localparam int LOG_BEAT = $clog2(DATA_W / 8);
  localparam int BEAT_W   = 16;

  fan_state_e            state_q, state_d;
  logic [2:0]            param_q, param_d;
  logic [3:0]            size_q, size_d;
  logic [SOURCE_W-1:0]   source_q, source_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [N_CLIENTS-1:0]  issue_q, issue_d;
  logic [N_CLIENTS-1:0]  pend_q, pend_d;
  logic [N_CLIENTS-1:0]  acked_q, acked_d;
  logic                  dirty_q, dirty_d;
  logic                  err_q, err_d;
  logic                  burst_q, burst_d;
  logic [BEAT_W-1:0]     rem_q, rem_d;
  logic [CID_W-1:0]      bcid_q, bcid_d;
  logic                  bdirty_q, bdirty_d;

  logic [N_CLIENTS-1:0]  enc_oh;
  logic [CID_W-1:0]      enc_idx;
  logic                  enc_valid;
  logic [CID_W-1:0]      pa_cid;
  logic [N_CLIENTS-1:0]  pa_oh;
  logic [BEAT_W-1:0]     pa_beats;
  logic                  ack_done;
  logic                  ack_dirty;
  logic [N_CLIENTS-1:0]  ack_oh;
  logic                  unused_pa_bits;

  tl_prio_enc #(.N(N_CLIENTS)) u_issue_sel (
    .req_i    (issue_q),
    .onehot_o (enc_oh),
    .idx_o    (enc_idx),
    .valid_o  (enc_valid)
  );

  assign unused_pa_bits = ^{pa_param_i, pa_source_i[SOURCE_W-1:0]};

  // Out-of-range client IDs shift to zero and therefore never look pending.
  assign pa_cid = pa_source_i[M_SOURCE_W-1 -: CID_W];
  assign pa_oh  = N_CLIENTS'(1) << pa_cid;

  always_comb begin
    pa_beats = BEAT_W'(1);
    if (pa_opcode_i == C_PROBE_ACK_DATA && pa_size_i > 4'(LOG_BEAT)) begin
      pa_beats = BEAT_W'(1) << (pa_size_i - 4'(LOG_BEAT));
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign b_valid_o    = (state_q == ST_ISSUE) && enc_valid;
  assign pa_ready_o   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done_valid_o = (state_q == ST_DONE);
  assign b_opcode_o   = B_PROBE;
  assign b_param_o    = param_q;
  assign b_size_o     = size_q;
  assign b_source_o   = source_q;
  assign b_address_o  = addr_q;
  assign b_mask_o     = '1;
  assign b_data_o     = '0;
  assign b_corrupt_o  = 1'b0;
  assign b_dest_o     = enc_idx;
  assign done_dirty_o = dirty_q;
  assign done_acked_o = acked_q;
  assign err_o        = err_q;

  always_comb begin
    state_d   = state_q;
    param_d   = param_q;
    size_d    = size_q;
    source_d  = source_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    pend_d    = pend_q;
    acked_d   = acked_q;
    dirty_d   = dirty_q;
    err_d     = err_q;
    burst_d   = burst_q;
    rem_d     = rem_q;
    bcid_d    = bcid_q;
    bdirty_d  = bdirty_q;
    ack_done  = 1'b0;
    ack_dirty = 1'b0;
    ack_oh    = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          param_d  = req_param_i;
          size_d   = req_size_i;
          source_d = req_source_i;
          addr_d   = req_address_i;
          issue_d  = req_mask_i;
          pend_d   = req_mask_i;
          acked_d  = '0;
          dirty_d  = 1'b0;
          burst_d  = 1'b0;
          rem_d    = '0;
          state_d  = (req_mask_i != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready_i) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A client may only ack after its probe left, i.e. pending but no longer queued.
    if (pa_ready_o && pa_valid_i) begin
      if (burst_q) begin
        if (pa_cid != bcid_q) begin
          err_d = 1'b1;
        end else begin
          rem_d = rem_q - BEAT_W'(1);
          if (rem_q == BEAT_W'(1)) begin
            burst_d   = 1'b0;
            ack_done  = 1'b1;
            ack_dirty = bdirty_q;
            ack_oh    = N_CLIENTS'(1) << bcid_q;
          end
        end
      end else if (!(pa_opcode_i == C_PROBE_ACK || pa_opcode_i == C_PROBE_ACK_DATA) ||
                   ((pend_q & ~issue_q & pa_oh) == '0)) begin
        err_d = 1'b1;
      end else if (pa_beats == BEAT_W'(1)) begin
        ack_done  = 1'b1;
        ack_dirty = (pa_opcode_i == C_PROBE_ACK_DATA);
        ack_oh    = pa_oh;
      end else begin
        burst_d  = 1'b1;
        rem_d    = pa_beats - BEAT_W'(1);
        bcid_d   = pa_cid;
        bdirty_d = (pa_opcode_i == C_PROBE_ACK_DATA);
      end
    end

    if (ack_done) begin
      pend_d  = pend_q & ~ack_oh;
      acked_d = acked_q | ack_oh;
      dirty_d = dirty_q | ack_dirty;
    end

    if (b_valid_o && b_ready_i) issue_d = issue_q & ~enc_oh;

    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && issue_d == '0) begin
      state_d = (pend_d == '0) ? ST_DONE : ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      param_q  <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      issue_q  <= '0;
      pend_q   <= '0;
      acked_q  <= '0;
      dirty_q  <= 1'b0;
      err_q    <= 1'b0;
      burst_q  <= 1'b0;
      rem_q    <= '0;
      bcid_q   <= '0;
      bdirty_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      param_q  <= param_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      issue_q  <= issue_d;
      pend_q   <= pend_d;
      acked_q  <= acked_d;
      dirty_q  <= dirty_d;
      err_q    <= err_d;
      burst_q  <= burst_d;
      rem_q    <= rem_d;
      bcid_q   <= bcid_d;
      bdirty_q <= bdirty_d;
    end
  end

endmodule

// File: tb/tb_tl_probe_fanout.sv
// Bench for tl_probe_fanout: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_tl_probe_fanout;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int SW  = 4;
  localparam int MSW = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic [2:0]     req_param_i = '0;
  logic [3:0]     req_size_i = '0;
  logic [SW-1:0]  req_source_i = '0;
  logic [AW-1:0]  req_address_i = '0;
  logic [N-1:0]   req_mask_i = '0;
  logic           b_valid_o;
  logic           b_ready_i = 1'b0;
  logic [2:0]     b_opcode_o;
  logic [2:0]     b_param_o;
  logic [3:0]     b_size_o;
  logic [SW-1:0]  b_source_o;
  logic [AW-1:0]  b_address_o;
  logic [7:0]     b_mask_o;
  logic [DW-1:0]  b_data_o;
  logic           b_corrupt_o;
  logic [1:0]     b_dest_o;
  logic           pa_valid_i = 1'b0;
  logic           pa_ready_o;
  logic [2:0]     pa_opcode_i = 3'd4;
  logic [2:0]     pa_param_i = '0;
  logic [3:0]     pa_size_i = '0;
  logic [MSW-1:0] pa_source_i = '0;
  logic           done_valid_o;
  logic           done_ready_i = 1'b0;
  logic           done_dirty_o;
  logic [N-1:0]   done_acked_o;
  logic           err_o;

  always #5 clk = ~clk;

  tl_probe_fanout #(
    .N_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .SOURCE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_param_i(req_param_i),
    .req_size_i(req_size_i), .req_source_i(req_source_i), .req_address_i(req_address_i),
    .req_mask_i(req_mask_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_opcode_o(b_opcode_o),
    .b_param_o(b_param_o), .b_size_o(b_size_o), .b_source_o(b_source_o),
    .b_address_o(b_address_o), .b_mask_o(b_mask_o), .b_data_o(b_data_o),
    .b_corrupt_o(b_corrupt_o), .b_dest_o(b_dest_o),
    .pa_valid_i(pa_valid_i), .pa_ready_o(pa_ready_o), .pa_opcode_i(pa_opcode_i),
    .pa_param_i(pa_param_i), .pa_size_i(pa_size_i), .pa_source_i(pa_source_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_dirty_o(done_dirty_o),
    .done_acked_o(done_acked_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  int completed = 0;

  // Transaction-level reference: probes still to send, clients still owing an
  // ack, and the progress of the multi-beat ack currently being received.
  bit          m_busy, m_done, m_err, m_dirty;
  bit [N-1:0]  m_pending, m_issued, m_acked;
  int          m_toIssue[$];
  int          m_burstCid, m_burstSeen, m_burstTotal, m_burstSize;
  bit          m_burstDirty;
  logic [2:0]  m_param;
  logic [3:0]  m_size;
  logic [SW-1:0] m_source;
  logic [AW-1:0] m_addr;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int beatsFor(input logic [2:0] op, input logic [3:0] size);
    int lb;
    lb = $clog2(DW / 8);
    if (op == 3'd4 || int'(size) <= lb) return 1;
    return 2 ** (int'(size) - lb);
  endfunction

  task automatic modelReset();
    m_busy = 0; m_done = 0; m_err = 0; m_dirty = 0;
    m_pending = '0; m_issued = '0; m_acked = '0;
    m_toIssue.delete();
    m_burstTotal = 0; m_burstSeen = 0; m_burstCid = 0; m_burstSize = 0; m_burstDirty = 0;
    m_param = '0; m_size = '0; m_source = '0; m_addr = '0;
  endtask

  task automatic completeAck(input int cid, input bit dirty);
    m_pending[cid] = 1'b0;
    m_acked[cid] = 1'b1;
    m_dirty = m_dirty | dirty;
  endtask

  task automatic handleAck();
    int cid;
    int beats;
    cid = int'(pa_source_i[MSW-1:SW]);
    if (m_burstTotal > 0) begin
      if (cid != m_burstCid) m_err = 1;
      else begin
        m_burstSeen++;
        if (m_burstSeen == m_burstTotal) begin
          completeAck(m_burstCid, m_burstDirty);
          m_burstTotal = 0;
        end
      end
    end else if (!(pa_opcode_i == 3'd4 || pa_opcode_i == 3'd5) || cid >= N ||
                 !m_pending[cid] || !m_issued[cid]) begin
      m_err = 1;
    end else begin
      beats = beatsFor(pa_opcode_i, pa_size_i);
      if (beats == 1) completeAck(cid, pa_opcode_i == 3'd5);
      else begin
        m_burstTotal = beats;
        m_burstSeen = 1;
        m_burstCid = cid;
        m_burstDirty = (pa_opcode_i == 3'd5);
        m_burstSize = int'(pa_size_i);
      end
    end
  endtask

  task automatic checkCycle();
    bit expB;
    expB = m_busy && (m_toIssue.size() > 0);
    checkOutput("req_ready", req_ready_o, !m_busy && !m_done);
    checkOutput("b_valid", b_valid_o, expB);
    checkOutput("pa_ready", pa_ready_o, m_busy);
    checkOutput("done_valid", done_valid_o, m_done);
    checkOutput("err", err_o, m_err);
    if (expB) begin
      checkOutput("b_dest", b_dest_o, m_toIssue[0]);
      checkOutput("b_opcode", b_opcode_o, 3'd6);
      checkOutput("b_param", b_param_o, m_param);
      checkOutput("b_size", b_size_o, m_size);
      checkOutput("b_source", b_source_o, m_source);
      checkOutput("b_address", b_address_o, m_addr);
      checkOutput("b_mask", b_mask_o, 8'hFF);
      checkOutput("b_data", b_data_o, '0);
      checkOutput("b_corrupt", b_corrupt_o, 1'b0);
    end
    if (m_done) begin
      checkOutput("done_acked", done_acked_o, m_acked);
      checkOutput("done_dirty", done_dirty_o, m_dirty);
    end
  endtask

  task automatic modelStep();
    bit reqHs, bHs, paHs, doneHs;
    reqHs  = !m_busy && !m_done && req_valid_i;
    bHs    = m_busy && (m_toIssue.size() > 0) && b_ready_i;
    paHs   = m_busy && pa_valid_i;
    doneHs = m_done && done_ready_i;
    if (doneHs) begin
      m_done = 0;
      completed++;
    end
    if (reqHs) begin
      m_param = req_param_i; m_size = req_size_i; m_source = req_source_i; m_addr = req_address_i;
      m_pending = req_mask_i; m_issued = '0; m_acked = '0; m_dirty = 0; m_burstTotal = 0;
      m_toIssue.delete();
      for (int i = 0; i < N; i++) if (req_mask_i[i]) m_toIssue.push_back(i);
      if (req_mask_i == '0) m_done = 1;
      else m_busy = 1;
    end
    if (paHs) handleAck();
    if (bHs) begin
      m_issued[m_toIssue[0]] = 1'b1;
      void'(m_toIssue.pop_front());
    end
    if (m_busy && m_toIssue.size() == 0 && m_pending == '0) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) modelReset();
    else begin
      checkCycle();
      modelStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input logic [N-1:0] mask, input logic [2:0] param, input logic [3:0] size,
                         input logic [SW-1:0] src, input logic [AW-1:0] addr);
    req_valid_i = 1; req_mask_i = mask; req_param_i = param; req_size_i = size;
    req_source_i = src; req_address_i = addr;
    tick();
    req_valid_i = 0;
  endtask

  task automatic sendAck(input int cid, input logic [2:0] op, input logic [3:0] size);
    pa_valid_i = 1; pa_opcode_i = op; pa_size_i = size;
    pa_source_i = {2'(cid), 4'h0};
    tick();
    pa_valid_i = 0;
  endtask

  task automatic finishTxn();
    done_ready_i = 1;
    tick();
    done_ready_i = 0;
  endtask

  task automatic applyStimulus();
    int cands[$];
    int pick;
    req_valid_i   = ($urandom_range(0, 2) == 0);
    req_mask_i    = 4'($urandom_range(0, 15));
    req_param_i   = 3'($urandom_range(0, 2));
    req_size_i    = 4'($urandom_range(0, 6));
    req_source_i  = 4'($urandom_range(0, 15));
    req_address_i = {$urandom, $urandom};
    b_ready_i     = ($urandom_range(0, 3) != 0);
    done_ready_i  = ($urandom_range(0, 1) == 1);
    pa_param_i    = 3'($urandom_range(0, 7));
    pa_valid_i    = 0;
    pa_opcode_i   = 3'd4;
    pa_size_i     = '0;
    pa_source_i   = '0;
    if (m_burstTotal > 0) begin
      pa_valid_i  = ($urandom_range(0, 3) != 0);
      pa_opcode_i = 3'd5;
      pa_size_i   = 4'(m_burstSize);
      pa_source_i = {2'(m_burstCid), 4'($urandom_range(0, 15))};
    end else begin
      for (int i = 0; i < N; i++) if (m_pending[i] && m_issued[i]) cands.push_back(i);
      if ($urandom_range(0, 9) == 0) begin
        pa_valid_i  = 1;
        pa_opcode_i = 3'($urandom_range(0, 7));
        pa_size_i   = 4'($urandom_range(0, 6));
        pa_source_i = 6'($urandom_range(0, 63));
      end else if (cands.size() > 0 && $urandom_range(0, 2) != 0) begin
        pick = cands[$urandom_range(0, cands.size() - 1)];
        pa_valid_i  = 1;
        pa_opcode_i = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd4;
        pa_size_i   = 4'($urandom_range(0, 6));
        pa_source_i = {2'(pick), 4'($urandom_range(0, 15))};
      end
    end
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    checkOutput("reset_req_ready", req_ready_o, 1'b1);
    checkOutput("reset_b_valid", b_valid_o, 1'b0);
    checkOutput("reset_pa_ready", pa_ready_o, 1'b0);
    checkOutput("reset_done_valid", done_valid_o, 1'b0);
    checkOutput("reset_err", err_o, 1'b0);

    // Three-client probe with back-to-back issue and clean acks.
    b_ready_i = 1;
    sendReq(4'b1011, 3'd2, 4'd6, 4'h3, 64'h0000_0000_8000_0040);
    checkOutput("t1_dest0", {b_valid_o, b_dest_o}, 3'b1_00);
    tick();
    checkOutput("t1_dest1", {b_valid_o, b_dest_o}, 3'b1_01);
    tick();
    checkOutput("t1_dest3", {b_valid_o, b_dest_o}, 3'b1_11);
    tick();
    checkOutput("t1_b_idle", b_valid_o, 1'b0);
    sendAck(0, 3'd4, 4'd6);
    sendAck(1, 3'd4, 4'd6);
    checkOutput("t1_not_done", done_valid_o, 1'b0);
    sendAck(3, 3'd4, 4'd6);
    checkOutput("t1_done", {done_valid_o, done_dirty_o, done_acked_o}, 6'b1_0_1011);
    finishTxn();

    // 64-byte ProbeAckData over a 64-bit beat is an eight-beat burst.
    sendReq(4'b0100, 3'd0, 4'd6, 4'h1, 64'h0000_0000_0000_1000);
    checkOutput("t2_dest2", {b_valid_o, b_dest_o}, 3'b1_10);
    tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput("t2_pa_ready", pa_ready_o, 1'b1);
      sendAck(2, 3'd5, 4'd6);
      checkOutput("t2_done_after_beat", done_valid_o, (k == 7));
    end
    checkOutput("t2_done_fields", {done_dirty_o, done_acked_o}, 5'b1_0100);
    finishTxn();

    // Back-pressured B channel holds every probe field steady.
    b_ready_i = 0;
    sendReq(4'b0011, 3'd1, 4'd6, 4'h5, 64'hDEAD_BEEF_0000_0040);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_stall_dest", {b_valid_o, b_dest_o}, 3'b1_00);
      checkOutput("t3_stall_addr", b_address_o, 64'hDEAD_BEEF_0000_0040);
      checkOutput("t3_stall_fields", {b_param_o, b_size_o, b_source_o}, {3'd1, 4'd6, 4'h5});
      tick();
    end
    b_ready_i = 1;
    checkOutput("t3_release_dest0", {b_valid_o, b_dest_o}, 3'b1_00);
    tick();
    checkOutput("t3_release_dest1", {b_valid_o, b_dest_o}, 3'b1_01);
    tick();
    sendAck(1, 3'd4, 4'd0);
    sendAck(0, 3'd5, 4'd3);
    checkOutput("t3_done", {done_valid_o, done_dirty_o, done_acked_o}, 6'b1_1_0011);
    finishTxn();

    // Empty mask completes immediately; completion held under back-pressure.
    sendReq(4'b0000, 3'd2, 4'd6, 4'h2, 64'h40);
    checkOutput("t4_done_empty", {done_valid_o, done_acked_o, b_valid_o}, 6'b1_0000_0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t4_done_held", {done_valid_o, req_ready_o}, 2'b10);
    end
    finishTxn();
    checkOutput("t4_back_idle", {req_ready_o, done_valid_o}, 2'b10);

    // Stray ack from an unprobed client flags an error but does not stall.
    sendReq(4'b0001, 3'd2, 4'd6, 4'h7, 64'h80);
    tick();
    sendAck(2, 3'd4, 4'd6);
    checkOutput("t5_err", {err_o, done_valid_o}, 2'b10);
    sendAck(0, 3'd4, 4'd6);
    checkOutput("t5_done", {done_valid_o, done_acked_o}, 5'b1_0001);
    finishTxn();

    // Reset in the middle of waiting for acks.
    sendReq(4'b0011, 3'd2, 4'd6, 4'h4, 64'hC0);
    tick();
    tick();
    checkOutput("t6_in_wait", {pa_ready_o, b_valid_o}, 2'b10);
    rst_n = 0;
    #1;
    checkOutput("t6_rst_ready", {req_ready_o, b_valid_o, pa_ready_o}, 3'b100);
    checkOutput("t6_rst_done", {done_valid_o, done_dirty_o, done_acked_o, err_o}, 7'b0);
    tick();
    rst_n = 1;
    b_ready_i = 0;

    for (int cyc = 0; cyc < 4000; cyc++) applyStimulus();
    checkOutput("random_progress", (completed > 20), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
